down_counter: RTL and testbench

- Loadable down-counter/timer for the RISC datapath; the count-down counterpart to the program counter.
- Software or the controller loads a count, then the block decrements once per enabled cycle.
- Flags terminal count with a one-cycle pulse; optionally auto-reloads for periodic events (loop counts, wait states, periodic ticks).

---
 rtl/down_counter_if.sv | 45 ++++
 rtl/down_counter.sv | 115 +++++++++++
 tb/tb_down_counter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/down_counter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : down_counter_if
// Description : Control/status bundle between a controller (master) and the
//               loadable down-counter (slave). The done line exists only when
//               DOWN_COUNTER_DONE_EN is defined.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface down_counter_if #(
  parameter int WIDTH = 3
);
  logic             load;
  logic             enab;
  logic             stop;
  logic             auto_rld;
  logic [WIDTH-1:0] cnt_in;
  logic [WIDTH-1:0] cnt_out;
  logic             zero;
  logic             busy;
  logic             tc;
`ifdef DOWN_COUNTER_DONE_EN
  logic             done;

  modport master (
    output load, enab, stop, auto_rld, cnt_in,
    input  cnt_out, zero, busy, tc, done
  );

  modport slave (
    input  load, enab, stop, auto_rld, cnt_in,
    output cnt_out, zero, busy, tc, done
  );
`else
  modport master (
    output load, enab, stop, auto_rld, cnt_in,
    input  cnt_out, zero, busy, tc
  );

  modport slave (
    input  load, enab, stop, auto_rld, cnt_in,
    output cnt_out, zero, busy, tc
  );
`endif
endinterface
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : down_counter
// Description : Loadable down-counter/timer. Loads a count, decrements once
//               per enabled cycle while running, pulses tc for one cycle on
//               expiry and optionally auto-reloads for periodic events.
//               Optional sticky done flag: define DOWN_COUNTER_DONE_EN.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module down_counter #(
  parameter int WIDTH = 3
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  down_counter_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_zero = '0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_rld;
  logic [WIDTH-1:0] w_rld_nxt;
  logic             r_tc;
  logic             w_tc_nxt;
`ifdef DOWN_COUNTER_DONE_EN
  logic             r_done;
  logic             w_done_nxt;
`endif

  // State, count, reload value and tc pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= c_zero;
      r_rld   <= c_zero;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rld   <= w_rld_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

`ifdef DOWN_COUNTER_DONE_EN
  // Sticky done flag; set with tc, cleared only by load or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
    end
  end
`endif

  // Next-state logic with priority load > stop > enab.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rld_nxt   = r_rld;
    w_tc_nxt    = 1'b0;
`ifdef DOWN_COUNTER_DONE_EN
    w_done_nxt  = r_done;
`endif
    if (bus.load) begin
      w_cnt_nxt   = bus.cnt_in;
      w_rld_nxt   = bus.cnt_in;
      w_state_nxt = (bus.cnt_in != c_zero) ? S_RUN : S_IDLE;
`ifdef DOWN_COUNTER_DONE_EN
      w_done_nxt  = 1'b0;
`endif
    end else if (bus.stop) begin
      // Abort keeps the count so software can read where it stopped.
      w_state_nxt = S_IDLE;
    end else if (r_state == S_RUN && bus.enab) begin
      if (r_cnt == c_one) begin
        w_tc_nxt = 1'b1;
`ifdef DOWN_COUNTER_DONE_EN
        w_done_nxt = 1'b1;
`endif
        if (bus.auto_rld) begin
          // Reload value is nonzero whenever RUN was entered, so RUN persists.
          w_cnt_nxt = r_rld;
        end else begin
          w_cnt_nxt   = c_zero;
          w_state_nxt = S_IDLE;
        end
      end else if (r_cnt > c_one) begin
        w_cnt_nxt = r_cnt - c_one;
      end
    end
  end

  // Output mapping; zero is the only combinational status.
  always_comb begin
    bus.cnt_out = r_cnt;
    bus.zero    = (r_cnt == c_zero);
    bus.busy    = (r_state == S_RUN);
    bus.tc      = r_tc;
`ifdef DOWN_COUNTER_DONE_EN
    bus.done    = r_done;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_down_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_down_counter
// Description : Self-checking bench for down_counter: directed scenarios with
//               literal expectations plus randomized traffic compared against
//               a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_down_counter;
  localparam int W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  // Behavioural model state.
  int m_cnt  = 0;
  int m_rld  = 0;
  bit m_run  = 0;
  bit m_tc   = 0;
  bit m_done = 0;

  down_counter_if #(.WIDTH(W)) bus ();

  down_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit l, input bit s, input bit e, input bit a, input int v);
    bus.load     = l;
    bus.stop     = s;
    bus.enab     = e;
    bus.auto_rld = a;
    bus.cnt_in   = W'(v);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rld = 0; m_run = 0; m_tc = 0; m_done = 0;
  endtask

  // Model advance for one edge, from the rules: load > stop > enab.
  task automatic model_step();
    int v;
    v    = int'(bus.cnt_in);
    m_tc = 0;
    if (bus.load) begin
      m_cnt = v; m_rld = v; m_run = (v != 0); m_done = 0;
    end else if (bus.stop) begin
      m_run = 0;
    end else if (m_run && bus.enab) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_tc = 1; m_done = 1;
        if (bus.auto_rld) m_cnt = m_rld;
        else m_run = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_total++;
    if (bus.cnt_out !== 3'd0 || bus.zero !== 1'b1 || bus.busy !== 1'b0 || bus.tc !== 1'b0)
      $display("FAIL reset_init cnt/zero/busy/tc got %0d/%b/%b/%b want 0/1/0/0", bus.cnt_out, bus.zero, bus.busy, bus.tc);
    else n_pass++;
    #5 rst_n = 1'b1;
    drive(1, 0, 1, 0, 5);
    tick();
    drive(0, 0, 1, 0, 0);
    tick();
    n_total++;
    if (bus.cnt_out !== 3'd4 || bus.busy !== 1'b1)
      $display("FAIL reset_prerun cnt/busy got %0d/%b want 4/1", bus.cnt_out, bus.busy);
    else n_pass++;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (bus.cnt_out !== 3'd0 || bus.zero !== 1'b1 || bus.busy !== 1'b0 || bus.tc !== 1'b0)
      $display("FAIL reset_async cnt/zero/busy/tc got %0d/%b/%b/%b want 0/1/0/0", bus.cnt_out, bus.zero, bus.busy, bus.tc);
    else n_pass++;
    #1 rst_n = 1'b1;
    drive(0, 0, 1, 0, 0);
    tick();
    n_total++;
    if (bus.cnt_out !== 3'd0 || bus.busy !== 1'b0)
      $display("FAIL reset_idle_enab cnt/busy got %0d/%b want 0/0", bus.cnt_out, bus.busy);
    else n_pass++;
  endtask

  task automatic test_one_shot();
    int exp_cnt[5]  = '{3, 2, 1, 0, 0};
    bit exp_tc[5]   = '{0, 0, 0, 1, 0};
    bit exp_busy[5] = '{1, 1, 1, 0, 0};
    drive(1, 0, 1, 0, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) drive(0, 0, 1, 0, 0);
      n_total++;
      if (bus.cnt_out !== W'(exp_cnt[i]) || bus.tc !== exp_tc[i] || bus.busy !== exp_busy[i])
        $display("FAIL one_shot[%0d] cnt/tc/busy got %0d/%b/%b want %0d/%b/%b", i,
                 bus.cnt_out, bus.tc, bus.busy, exp_cnt[i], exp_tc[i], exp_busy[i]);
      else n_pass++;
    end
  endtask

  task automatic test_auto_reload();
    int exp_cnt[11] = '{5, 4, 3, 2, 1, 5, 4, 3, 2, 1, 5};
    drive(1, 0, 1, 1, 5);
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) drive(0, 0, 1, 1, 0);
      n_total++;
      if (bus.cnt_out !== W'(exp_cnt[i]) || bus.tc !== (i == 5 || i == 10) || bus.busy !== 1'b1)
        $display("FAIL auto_reload[%0d] cnt/tc/busy got %0d/%b/%b want %0d/%b/1", i,
                 bus.cnt_out, bus.tc, bus.busy, exp_cnt[i], (i == 5 || i == 10));
      else n_pass++;
    end
  endtask

  task automatic test_gaps_abort();
    int exp_cnt[4] = '{4, 3, 3, 2};
    bit en_seq[4]  = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 0, en_seq[i], 0, 4);
      tick();
      n_total++;
      if (bus.cnt_out !== W'(exp_cnt[i]) || bus.busy !== 1'b1 || bus.tc !== 1'b0)
        $display("FAIL gaps[%0d] cnt/busy/tc got %0d/%b/%b want %0d/1/0", i, bus.cnt_out, bus.busy, bus.tc, exp_cnt[i]);
      else n_pass++;
    end
    drive(0, 1, 1, 0, 0);
    tick();
    n_total++;
    if (bus.cnt_out !== 3'd2 || bus.busy !== 1'b0)
      $display("FAIL abort cnt/busy got %0d/%b want 2/0", bus.cnt_out, bus.busy);
    else n_pass++;
    drive(0, 0, 1, 0, 0);
    tick();
    tick();
    n_total++;
    if (bus.cnt_out !== 3'd2 || bus.busy !== 1'b0 || bus.tc !== 1'b0)
      $display("FAIL idle_ignores_enab cnt/busy/tc got %0d/%b/%b want 2/0/0", bus.cnt_out, bus.busy, bus.tc);
    else n_pass++;
    drive(1, 0, 1, 0, 7);
    tick();
    n_total++;
    if (bus.cnt_out !== 3'd7 || bus.busy !== 1'b1)
      $display("FAIL restart cnt/busy got %0d/%b want 7/1", bus.cnt_out, bus.busy);
    else n_pass++;
  endtask

  task automatic test_collisions();
    drive(1, 0, 1, 0, 2);
    tick();
    drive(0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 1, 0, 6);
    tick();
    n_total++;
    if (bus.cnt_out !== 3'd6 || bus.tc !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL load_vs_expiry cnt/tc/busy got %0d/%b/%b want 6/0/1", bus.cnt_out, bus.tc, bus.busy);
    else n_pass++;
    drive(1, 0, 1, 0, 1);
    tick();
    drive(0, 1, 1, 1, 0);
    tick();
    n_total++;
    if (bus.cnt_out !== 3'd1 || bus.tc !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL stop_vs_expiry cnt/tc/busy got %0d/%b/%b want 1/0/0", bus.cnt_out, bus.tc, bus.busy);
    else n_pass++;
    drive(1, 0, 1, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    tick();
    n_total++;
    if (bus.cnt_out !== 3'd0 || bus.zero !== 1'b1 || bus.busy !== 1'b0 || bus.tc !== 1'b0)
      $display("FAIL load_zero cnt/zero/busy/tc got %0d/%b/%b/%b want 0/1/0/0", bus.cnt_out, bus.zero, bus.busy, bus.tc);
    else n_pass++;
  endtask

`ifdef DOWN_COUNTER_DONE_EN
  task automatic test_done();
    bit exp_done[5] = '{0, 0, 1, 1, 1};
    drive(1, 0, 1, 1, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) drive(0, 0, 1, 1, 0);
      n_total++;
      if (bus.done !== exp_done[i])
        $display("FAIL done_sticky[%0d] got %b want %b", i, bus.done, exp_done[i]);
      else n_pass++;
    end
    drive(1, 0, 1, 1, 3);
    tick();
    n_total++;
    if (bus.done !== 1'b0 || bus.tc !== 1'b0)
      $display("FAIL done_clear done/tc got %b/%b want 0/0", bus.done, bus.tc);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, (1 << W) - 1)));
      tick();
      ok = (bus.cnt_out === W'(m_cnt)) && (bus.zero === (m_cnt == 0)) &&
           (bus.busy === m_run) && (bus.tc === m_tc);
`ifdef DOWN_COUNTER_DONE_EN
      ok = ok && (bus.done === m_done);
`endif
      n_total++;
      if (!ok)
        $display("FAIL random[%0d] cnt/zero/busy/tc got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                 bus.cnt_out, bus.zero, bus.busy, bus.tc, m_cnt, (m_cnt == 0), m_run, m_tc);
      else n_pass++;
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    model_reset();
    #12;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_gaps_abort();
    test_collisions();
`ifdef DOWN_COUNTER_DONE_EN
    test_done();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
